// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control unit: opcodes, ALU ops,
// PC/writeback selects, FSM states and decoded instruction classes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OPC_R    = 7'h33;
  localparam logic [6:0] OPC_I    = 7'h13;
  localparam logic [6:0] OPC_LW   = 7'h03;
  localparam logic [6:0] OPC_SW   = 7'h23;
  localparam logic [6:0] OPC_BR   = 7'h63;
  localparam logic [6:0] OPC_JAL  = 7'h6F;
  localparam logic [6:0] OPC_JALR = 7'h67;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JAL    = 2'b10;
  localparam logic [1:0] PC_JALR   = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  typedef enum logic [2:0] {T_R, T_I, T_LW, T_SW, T_BR, T_JAL, T_JALR, T_ILL} itype_e;
  typedef enum logic [1:0] {BC_EQ, BC_NE, BC_LT, BC_GE} bcond_e;

  function automatic logic br_taken(input bcond_e c, input logic z, input logic l);
    case (c)
      BC_EQ:   return z;
      BC_NE:   return !z;
      BC_LT:   return l;
      default: return !l;
    endcase
  endfunction

endpackage

// File: rtl/riscv_ctrl_decode.sv
// Combinational instruction classifier: instruction class, ALU op and branch
// condition. Anything outside the supported subset reports T_ILL.
module riscv_ctrl_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0] ins_i,
  output itype_e      itype_o,
  output logic [2:0]  alu_op_o,
  output bcond_e      bcond_o
);

  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_fields;

  assign f3 = ins_i[14:12];
  assign f7 = ins_i[31:25];
  assign unused_fields = ^{ins_i[24:15], ins_i[11:7]};

  always_comb begin
    itype_o  = T_ILL;
    alu_op_o = ALU_ADD;
    bcond_o  = BC_EQ;
    case (ins_i[6:0])
      OPC_R: begin
        if (f7 == 7'h20 && f3 == 3'b000) begin
          itype_o  = T_R;
          alu_op_o = ALU_SUB;
        end else if (f7 == 7'h00) begin
          case (f3)
            3'b000:  begin itype_o = T_R; alu_op_o = ALU_ADD; end
            3'b111:  begin itype_o = T_R; alu_op_o = ALU_AND; end
            3'b110:  begin itype_o = T_R; alu_op_o = ALU_OR;  end
            3'b010:  begin itype_o = T_R; alu_op_o = ALU_SLT; end
            default: ;
          endcase
        end
      end
      OPC_I:    if (f3 == 3'b000) itype_o = T_I;
      OPC_LW:   if (f3 == 3'b010) itype_o = T_LW;
      OPC_SW:   if (f3 == 3'b010) itype_o = T_SW;
      OPC_BR: begin
        case (f3)
          3'b000:  begin itype_o = T_BR; alu_op_o = ALU_SUB; bcond_o = BC_EQ; end
          3'b001:  begin itype_o = T_BR; alu_op_o = ALU_SUB; bcond_o = BC_NE; end
          3'b100:  begin itype_o = T_BR; alu_op_o = ALU_SLT; bcond_o = BC_LT; end
          3'b101:  begin itype_o = T_BR; alu_op_o = ALU_SLT; bcond_o = BC_GE; end
          default: ;
        endcase
      end
      OPC_JAL:  itype_o = T_JAL;
      OPC_JALR: if (f3 == 3'b000) itype_o = T_JALR;
      default:  ;
    endcase
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RISC-V control FSM with memory-wait timeout, sticky fault flags
// and a retired-instruction counter.
module riscv_mc_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ins,
  input  logic             zero,
  input  logic             lt,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [2:0]       op,
  output logic [1:0]       Mem2Reg,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic             ill_q, ill_d, to_q, to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire, wait_expired;

  itype_e     itype;
  logic [2:0] alu_op;
  bcond_e     bcond;

  riscv_ctrl_decode u_dec (
    .ins_i    (ins),
    .itype_o  (itype),
    .alu_op_o (alu_op),
    .bcond_o  (bcond)
  );

  // The current wait cycle is the TIMEOUT-th consecutive one without mem_ready.
  assign wait_expired = (TIMEOUT != 0) && (int'(wait_q) == TIMEOUT - 1);

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    ill_d    = ill_q;
    to_d     = to_q;
    cnt_d    = cnt_q;
    retire   = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src   = PC_PLUS4;
    RegWrite = 1'b0;
    ALUSrc   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    op       = ALU_AND;
    Mem2Reg  = WB_ALU;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          wait_d   = '0;
          state_d  = S_DECODE;
        end else if (wait_expired) begin
          to_d    = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: begin
        if (itype == T_ILL) begin
          ill_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        op     = alu_op;
        ALUSrc = (itype != T_R) && (itype != T_BR);
        case (itype)
          T_R, T_I:   state_d = S_WB;
          T_LW, T_SW: state_d = S_MEM;
          T_BR: begin
            pc_write = br_taken(bcond, zero, lt);
            pc_src   = PC_BRANCH;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          T_JAL, T_JALR: begin
            RegWrite = 1'b1;
            Mem2Reg  = WB_PC4;
            pc_write = 1'b1;
            pc_src   = (itype == T_JAL) ? PC_JAL : PC_JALR;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        // Address stays on the ALU while the access is outstanding.
        ALUSrc   = 1'b1;
        op       = ALU_ADD;
        MemRead  = (itype == T_LW);
        MemWrite = (itype == T_SW);
        if (mem_ready) begin
          wait_d = '0;
          if (itype == T_LW) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end else if (wait_expired) begin
          to_d    = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        Mem2Reg  = (itype == T_LW) ? WB_MEM : WB_ALU;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:  ;
      default: state_d = S_HALT;
    endcase
    if (retire) cnt_d = cnt_q + 1'b1;
    // Reset wins over everything, including a completing memory access.
    if (rst) begin
      ir_write = 1'b0;
      pc_write = 1'b0;
      pc_src   = PC_PLUS4;
      RegWrite = 1'b0;
      ALUSrc   = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      op       = ALU_AND;
      Mem2Reg  = WB_ALU;
    end
  end

  assign illegal     = ill_q & ~rst;
  assign timeout     = to_q & ~rst;
  assign instr_count = rst ? '0 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Scoreboard bench: a per-instruction reference model queues the expected
// output bundle for every cycle; a negedge monitor pops and compares.
module tb_riscv_mc_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, zero, lt, mem_ready;
  logic [31:0] ins;
  logic        ir_write, pc_write, RegWrite, ALUSrc, MemRead, MemWrite, illegal, timeout;
  logic [1:0]  pc_src, Mem2Reg;
  logic [2:0]  op;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  riscv_mc_ctrl #(.CNT_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ins(ins), .zero(zero), .lt(lt), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .RegWrite(RegWrite),
    .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite), .op(op),
    .Mem2Reg(Mem2Reg), .illegal(illegal), .timeout(timeout), .instr_count(instr_count)
  );

  typedef struct packed {
    logic irw, pcw; logic [1:0] pcs; logic rw, asrc, mr, mw;
    logic [2:0] op; logic [1:0] m2r; logic ill, to; logic [31:0] cnt;
  } obs_t;
  typedef struct { obs_t e; bit c_alu; bit c_pcs; string tag; } exp_t;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_JAL = 5, K_JALR = 6, K_ILL = 7;

  exp_t sbq[$];
  int   n_chk = 0, n_fail = 0;
  int   model_cnt = 0, abort_at = -1, k_cyc = 0;
  bit   model_ill = 0, model_to = 0, aborted = 0, halted = 0;

  // Monitor: op/ALUSrc only matter where the ALU result is consumed,
  // pc_src only where the PC may update, Mem2Reg only with RegWrite.
  always @(negedge clk) begin : mon
    exp_t x;
    obs_t a, m;
    if (sbq.size() > 0) begin
      x = sbq.pop_front();
      a = {ir_write, pc_write, pc_src, RegWrite, ALUSrc, MemRead, MemWrite, op, Mem2Reg,
           illegal, timeout, instr_count};
      m = '1;
      if (!x.c_alu) begin m.asrc = 1'b0; m.op = '0; end
      if (!x.c_pcs) m.pcs = '0;
      if (!x.e.rw)  m.m2r = '0;
      n_chk++;
      if ((a & m) !== (x.e & m)) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (care %h) t=%0t", x.tag, a, x.e, m, $time);
      end
    end
  end

  function automatic obs_t mk(logic irw, logic pcw, logic [1:0] pcs, logic rw, logic asrc,
                              logic mr, logic mw, logic [2:0] o, logic [1:0] m2r);
    obs_t e;
    e = '0;
    e.irw = irw; e.pcw = pcw; e.pcs = pcs; e.rw = rw; e.asrc = asrc;
    e.mr = mr; e.mw = mw; e.op = o; e.m2r = m2r;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic emit(input logic mr, input obs_t e, input bit c_alu, input bit c_pcs,
                      input string tag);
    exp_t x;
    if (aborted) return;
    if (k_cyc == abort_at) begin
      rst = 1'b1; mem_ready = mr;
      x.e = '0; x.c_alu = 0; x.c_pcs = 0; x.tag = {"abort-", tag};
      sbq.push_back(x);
      tick();
      rst = 1'b0;
      model_cnt = 0; model_ill = 0; model_to = 0; aborted = 1;
      return;
    end
    rst = 1'b0; mem_ready = mr;
    e.ill = model_ill; e.to = model_to; e.cnt = model_cnt;
    x.e = e; x.c_alu = c_alu; x.c_pcs = c_pcs; x.tag = tag;
    sbq.push_back(x);
    tick();
    k_cyc++;
  endtask

  task automatic do_reset(input int n);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      rst = 1'b1; mem_ready = 1'($urandom);
      x.e = '0; x.c_alu = 0; x.c_pcs = 0; x.tag = "reset";
      sbq.push_back(x);
      tick();
    end
    rst = 1'b0;
    model_cnt = 0; model_ill = 0; model_to = 0;
  endtask

  task automatic halt_cycles();
    for (int i = 0; i < 3; i++) emit(1'($urandom), mk(0,0,0,0,0,0,0,0,0), 0, 0, "halt");
    halted = !aborted;
  endtask

  // Reference model of one instruction: derives the class from the encoding and
  // emits the expected bundle for each cycle given the memory wait pattern.
  task automatic run_instr(input logic [31:0] iv, input logic z, input logic l,
                           input int fw, input int mw, input int ab);
    logic [6:0] opc, f7;
    logic [2:0] f3, aop;
    bit         legal, asrc, taken;
    int         kind;
    opc = iv[6:0]; f3 = iv[14:12]; f7 = iv[31:25];
    legal = 0; aop = 3'b010; asrc = 1; taken = 0; kind = K_ILL;
    case (opc)
      7'h33: begin
        kind = K_R; asrc = 0;
        if (f7 == 7'h20 && f3 == 3'd0) begin legal = 1; aop = 3'b110; end
        else if (f7 == 7'h00) begin
          if (f3 == 3'd0) begin legal = 1; aop = 3'b010; end
          if (f3 == 3'd7) begin legal = 1; aop = 3'b000; end
          if (f3 == 3'd6) begin legal = 1; aop = 3'b001; end
          if (f3 == 3'd2) begin legal = 1; aop = 3'b111; end
        end
      end
      7'h13: begin kind = K_I;  legal = (f3 == 3'd0); end
      7'h03: begin kind = K_LW; legal = (f3 == 3'd2); end
      7'h23: begin kind = K_SW; legal = (f3 == 3'd2); end
      7'h63: begin
        kind = K_BR; asrc = 0;
        if (f3 == 3'd0) begin legal = 1; aop = 3'b110; taken = z;  end
        if (f3 == 3'd1) begin legal = 1; aop = 3'b110; taken = !z; end
        if (f3 == 3'd4) begin legal = 1; aop = 3'b111; taken = l;  end
        if (f3 == 3'd5) begin legal = 1; aop = 3'b111; taken = !l; end
      end
      7'h6F: begin kind = K_JAL;  legal = 1; end
      7'h67: begin kind = K_JALR; legal = (f3 == 3'd0); end
      default: ;
    endcase
    ins = iv; zero = z; lt = l;
    abort_at = ab; k_cyc = 0; aborted = 0; halted = 0;

    for (int i = 0; i < fw && i < TO; i++) emit(0, mk(0,0,0,0,0,1,0,0,0), 0, 0, "fetch-wait");
    if (aborted) return;
    if (fw >= TO) begin model_to = 1; halt_cycles(); return; end
    emit(1, mk(1,1,2'b00,0,0,1,0,0,0), 0, 1, "fetch");
    emit(1'($urandom), mk(0,0,0,0,0,0,0,0,0), 0, 0, "decode");
    if (aborted) return;
    if (!legal) begin model_ill = 1; halt_cycles(); return; end

    case (kind)
      K_BR: begin
        emit(1'($urandom), mk(0,taken,2'b01,0,0,0,0,aop,0), 1, 1, "exec-branch");
        if (!aborted) model_cnt++;
        return;
      end
      K_JAL: begin
        emit(1'($urandom), mk(0,1,2'b10,1,0,0,0,0,2'b10), 0, 1, "exec-jal");
        if (!aborted) model_cnt++;
        return;
      end
      K_JALR: begin
        emit(1'($urandom), mk(0,1,2'b11,1,1,0,0,3'b010,2'b10), 1, 1, "exec-jalr");
        if (!aborted) model_cnt++;
        return;
      end
      default: emit(1'($urandom), mk(0,0,0,0,asrc,0,0,aop,0), 1, 0, "exec");
    endcase

    if (kind == K_LW || kind == K_SW) begin
      for (int i = 0; i < mw && i < TO; i++)
        emit(0, mk(0,0,0,0,0,kind == K_LW,kind == K_SW,0,0), 0, 0, "mem-wait");
      if (aborted) return;
      if (mw >= TO) begin model_to = 1; halt_cycles(); return; end
      emit(1, mk(0,0,0,0,0,kind == K_LW,kind == K_SW,0,0), 0, 0, "mem");
      if (kind == K_SW) begin
        if (!aborted) model_cnt++;
        return;
      end
    end
    emit(1'($urandom), mk(0,0,0,1,0,0,0,0,(kind == K_LW) ? 2'b01 : 2'b00), 0, 0, "wb");
    if (!aborted) model_cnt++;
  endtask

  task automatic run(input logic [31:0] iv, input logic z, input logic l,
                     input int fw, input int mw, input int ab);
    run_instr(iv, z, l, fw, mw, ab);
    if (halted) do_reset(2);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] iv;
    int          c;
    iv = $urandom;
    c  = $urandom_range(0, 9);
    case (c)
      0, 8: begin
        iv[6:0] = 7'h33;
        case ($urandom_range(0, 4))
          0: begin iv[31:25] = 7'h00; iv[14:12] = 3'd0; end
          1: begin iv[31:25] = 7'h20; iv[14:12] = 3'd0; end
          2: begin iv[31:25] = 7'h00; iv[14:12] = 3'd7; end
          3: begin iv[31:25] = 7'h00; iv[14:12] = 3'd6; end
          default: begin iv[31:25] = 7'h00; iv[14:12] = 3'd2; end
        endcase
      end
      1, 9: begin iv[6:0] = 7'h13; iv[14:12] = 3'd0; end
      2: begin iv[6:0] = 7'h03; iv[14:12] = 3'd2; end
      3: begin iv[6:0] = 7'h23; iv[14:12] = 3'd2; end
      4: begin
        iv[6:0] = 7'h63;
        case ($urandom_range(0, 3))
          0: iv[14:12] = 3'd0;
          1: iv[14:12] = 3'd1;
          2: iv[14:12] = 3'd4;
          default: iv[14:12] = 3'd5;
        endcase
      end
      5: iv[6:0] = 7'h6F;
      6: begin iv[6:0] = 7'h67; iv[14:12] = 3'd0; end
      default: ;
    endcase
    return iv;
  endfunction

  initial begin
    rst = 1'b1; ins = '0; zero = 1'b0; lt = 1'b0; mem_ready = 1'b0;
    tick();
    do_reset(2);

    run(32'h002081B3, 0, 0, 0, 0, -1);   // add: 4 cycles
    run(32'h0000A283, 0, 0, 0, 3, -1);   // lw with 3 memory waits: 8 cycles
    run(32'h00000463, 1, 0, 0, 0, -1);   // beq taken
    run(32'h00000463, 0, 0, 0, 0, -1);   // beq not taken
    run(32'h010000EF, 0, 0, 0, 0, -1);   // jal
    run(32'h0020C463, 0, 1, 1, 0, -1);   // blt taken after a fetch wait
    run(32'h0020D463, 0, 1, 0, 0, -1);   // bge not taken
    run(32'h0000A023, 0, 0, 0, 2, -1);   // sw
    run(32'h000080E7, 0, 0, 0, 0, -1);   // jalr
    run(32'h002081B3, 0, 0, 3, 0, -1);   // one wait short of the timeout
    run(32'h0000007F, 0, 0, 0, 0, -1);   // illegal opcode
    run(32'h002081B3, 0, 0, TO, 0, -1);  // fetch timeout
    run(32'h0000A283, 0, 0, 0, TO, -1);  // memory timeout during lw
    run(32'h002081B3, 0, 0, 0, 0, 3);    // reset lands on the WB cycle
    run(32'h002081B3, 0, 0, 0, 0, 0);    // reset overrides a ready fetch
    run(32'h0000A023, 0, 0, 0, 0, 3);    // reset lands on the sw MEM cycle

    for (int n = 0; n < 400; n++) begin
      int fw, mw, ab;
      fw = ($urandom_range(0, 24) == 0) ? TO : $urandom_range(0, 3);
      mw = ($urandom_range(0, 24) == 0) ? TO : $urandom_range(0, 3);
      ab = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 7) : -1;
      run(rand_ins(), 1'($urandom), 1'($urandom), fw, mw, ab);
    end

    @(negedge clk);
    #1;
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected cycles never compared, required 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_mc_ctrl.md
RISCV_MC_CTRL -- requirements
Module: riscv_mc_ctrl

Interface
REQ-001 Parameter CNT_W, 32, width of retired-instruction counter.
REQ-002 Parameter TIMEOUT, 16, max cycles waiting on mem_ready before fault; 0 disables the timeout.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ins  input  32  instruction register contents, stable except after ir_write.
REQ-006 zero  input  1  ALU result == 0.
REQ-007 lt  input  1  ALU signed rs1 < rs2.
REQ-008 mem_ready  input  1  memory completes the current access this cycle.
REQ-009 ir_write  output  1  load instruction register.
REQ-010 pc_write  output  1  update PC.
REQ-011 pc_src  output  2  00 PC+4, 01 branch target, 10 jal target, 11 ALU result (jalr).
REQ-012 RegWrite, ALUSrc, MemRead, MemWrite  output  1 each  datapath strobes, same meaning as the single-cycle datapath.
REQ-013 op  output  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-014 Mem2Reg  output  2  writeback select: 00 ALU, 01 memory, 10 PC+4.
REQ-015 illegal  output  1  sticky: unsupported opcode or funct seen.
REQ-016 timeout  output  1  sticky: memory wait exceeded TIMEOUT.
REQ-017 instr_count  output  CNT_W  retired instructions, wraps modulo 2^CNT_W.

Function
REQ-018 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT; outputs are a Moore function of the state plus the decoded ins.
REQ-019 FETCH SHALL assert MemRead, hold until mem_ready, then pulse ir_write and pc_write with pc_src=00, then move to DECODE.
REQ-020 DECODE SHALL move to EXEC for a supported instruction, else to HALT with illegal set.
REQ-021 Supported: 0x33 add/sub/and/or/slt; 0x13 addi; 0x03 lw (funct3 010); 0x23 sw (funct3 010); 0x63 beq/bne/blt/bge; 0x6F jal; 0x67 jalr; all others are illegal.
REQ-022 R-type/addi SHALL take EXEC, then WB (RegWrite=1, Mem2Reg=00), then FETCH; ALUSrc=0 for R-type, 1 for addi.
REQ-023 lw SHALL take EXEC (ADD, ALUSrc=1), then MEM (MemRead held until mem_ready), then WB (Mem2Reg=01), then FETCH.
REQ-024 sw SHALL take EXEC, then MEM (MemWrite held until mem_ready), then FETCH; RegWrite stays 0.
REQ-025 Branch SHALL do SUB or SLT in EXEC; pc_write=taken with pc_src=01; taken = zero (beq), !zero (bne), lt (blt), !lt (bge); then FETCH.
REQ-026 jal/jalr SHALL in EXEC assert RegWrite with Mem2Reg=10 and pc_write, using pc_src 10 (jal) or 11 (jalr, ADD, ALUSrc=1); then FETCH.
REQ-027 Latency with mem_ready immediate: branch/jal/jalr 3 cycles, R/I/sw 4, lw 5; each wait cycle adds 1.
REQ-028 instr_count SHALL increment on the final cycle of each instruction; never in HALT or on illegal instructions.
REQ-029 A wait counter SHALL count cycles with mem_ready=0 in FETCH/MEM; at TIMEOUT it SHALL go to HALT and set timeout; the counter clears on mem_ready.
REQ-030 HALT SHALL drive all strobes to 0 and remain until rst.
REQ-031 RegWrite to x0 is still asserted; the register file discards it.

Reset
REQ-032 While rst=1 all strobes, illegal, timeout and instr_count SHALL be 0; the state enters FETCH on the first edge after deassert.
REQ-033 rst mid-instruction SHALL abort it with no write strobe on that cycle; rst overrides mem_ready.

Structure
REQ-034 Package riscv_ctrl_pkg SHALL hold opcode constants, ALU op codes, pc_src/Mem2Reg encodings and the state enum.
REQ-035 Sub-module riscv_ctrl_decode (combinational) SHALL classify ins into type, ALU op and branch condition.

Verification
REQ-036 ins=0x002081B3 (add x3,x1,x2), ready=1 -> FETCH, DECODE, EXEC, WB; RegWrite=1 in WB only; op=010; instr_count +1.
REQ-037 ins=0x0000A283 (lw x5,0(x1)), mem_ready low 3 cycles in MEM -> 8 cycles total; Mem2Reg=01 in WB.
REQ-038 ins=0x00000463 (beq x0,x0,8), zero=1 -> pc_write=1, pc_src=01 in EXEC; with zero=0 -> pc_write=0 in EXEC.
REQ-039 ins=0x010000EF (jal x1,16) -> EXEC: RegWrite=1, Mem2Reg=10, pc_src=10; 3 cycles total.
REQ-040 ins=0x0000007F -> HALT with illegal=1 and the count unchanged; also TIMEOUT=4 with mem_ready=0 -> timeout=1 after 4 cycles; rst -> FETCH.
